// File: rtl/modexp_driver.sv
// modexp_driver: square-and-multiply modular exponentiation driving an external modulus reducer
module modexp_driver #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic [WIDTH-1:0]     base_in,
  input  logic [EXP_WIDTH-1:0] exponent_in,
  input  logic [WIDTH-1:0]     modulus_in,
  output logic [WIDTH-1:0]     result_out,
  output logic                 busy_out,
  output logic                 valid_out,
  output logic                 error_out,
  output logic                 red_ready_out,
  output logic [2*WIDTH-1:0]   red_value_out,
  output logic [WIDTH-1:0]     red_modulus_out,
  input  logic [WIDTH-1:0]     red_value_in,
  input  logic                 red_busy_in,
  input  logic                 red_valid_in
);
  localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  typedef enum logic [2:0] {
    IDLE, ISSUE_BASE, WAIT_BASE, ISSUE_SQ, WAIT_SQ, ISSUE_MUL, WAIT_MUL, DONE
  } state_e;
  state_e               state_q;
  logic [WIDTH-1:0]     base_q, acc_q, mod_q, result_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [BW-1:0]        bit_q;
  logic [2*WIDTH-1:0]   value_q, sq_d, mul_d;
  logic                 busy_q, valid_q, error_q;
  logic [WIDTH-1:0]     acc_d;
  // Operands are formed on entry to each ISSUE state so they are already registered when the request pulses.
  always_comb begin
    acc_d = (state_q == WAIT_MUL && exp_q[bit_q]) ? red_value_in : acc_q;
    sq_d  = {{WIDTH{1'b0}}, acc_d} * {{WIDTH{1'b0}}, acc_d};
    mul_d = {{WIDTH{1'b0}}, red_value_in} * {{WIDTH{1'b0}}, base_q};
  end
  // Control FSM; every run issues the multiply so the transaction count is exponent-independent.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      base_q   <= '0;
      acc_q    <= '0;
      mod_q    <= '0;
      result_q <= '0;
      exp_q    <= '0;
      bit_q    <= '0;
      value_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_in) begin
          mod_q <= modulus_in;
          if (modulus_in == '0) begin
            result_q <= '0;
            error_q  <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            base_q  <= base_in;
            exp_q   <= exponent_in;
            acc_q   <= WIDTH'(1);
            bit_q   <= BW'(EXP_WIDTH - 1);
            value_q <= {{WIDTH{1'b0}}, base_in};
            busy_q  <= 1'b1;
            state_q <= ISSUE_BASE;
          end
        end
        ISSUE_BASE: if (!red_busy_in) state_q <= WAIT_BASE;
        ISSUE_SQ:   if (!red_busy_in) state_q <= WAIT_SQ;
        ISSUE_MUL:  if (!red_busy_in) state_q <= WAIT_MUL;
        WAIT_BASE: if (red_valid_in) begin
          base_q  <= red_value_in;
          value_q <= sq_d;
          state_q <= ISSUE_SQ;
        end
        WAIT_SQ: if (red_valid_in) begin
          acc_q   <= red_value_in;
          value_q <= mul_d;
          state_q <= ISSUE_MUL;
        end
        WAIT_MUL: if (red_valid_in) begin
          acc_q <= acc_d;
          if (bit_q == '0) begin
            result_q <= acc_d;
            error_q  <= 1'b0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            bit_q   <= bit_q - 1'b1;
            value_q <= sq_d;
            state_q <= ISSUE_SQ;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          error_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign red_ready_out   = (state_q == ISSUE_BASE || state_q == ISSUE_SQ || state_q == ISSUE_MUL) && !red_busy_in;
  assign red_value_out   = value_q;
  assign red_modulus_out = mod_q;
  assign result_out      = result_q;
  assign busy_out        = busy_q;
  assign valid_out       = valid_q;
  assign error_out       = error_q;
endmodule

// File: tb/tb_modexp_driver.sv
// tb_modexp_driver: directed checks of modexp_driver against a behavioural reducer
module tb_modexp_driver;
  localparam int W = 16, E = 16, R = W + 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, spur = 1'b0;
  logic [W-1:0] base = '0, modv = '0;
  logic [E-1:0] expv = '0;
  logic [W-1:0] result, red_val, red_mod, rq = '0;
  logic [2*W-1:0] red_value;
  logic busy, valid, error, red_ready, red_busy, red_valid;
  int cnt = 0, checks = 0, errors = 0;
  logic [W-1:0] res;
  logic err, b1, bend;
  int cyc, pulses;

  always #5 clk = ~clk;

  modexp_driver #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .base_in(base),
    .exponent_in(expv), .modulus_in(modv), .result_out(result), .busy_out(busy),
    .valid_out(valid), .error_out(error), .red_ready_out(red_ready),
    .red_value_out(red_value), .red_modulus_out(red_mod), .red_value_in(red_val),
    .red_busy_in(red_busy), .red_valid_in(red_valid)
  );

  // reducer model: R cycles from ready to a one-cycle valid pulse
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 0;
      rq  <= '0;
    end else if (red_ready) begin
      cnt <= R;
      rq  <= W'(red_value % {{W{1'b0}}, red_mod});
    end else if (cnt != 0) cnt <= cnt - 1;

  assign red_busy  = cnt != 0;
  assign red_valid = (cnt == 1) | (spur & red_ready);
  assign red_val   = (cnt == 1) ? rq : 16'h5A5A;

  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic longint sw_modexp(input longint b, input longint e, input longint m);
    longint r = 1 % m;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = r * b % m;
      b = b * b % m;
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic run(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] m, input bit hold);
    @(negedge clk);
    base = b; expv = e; modv = m; start = 1'b1;
    cyc = 0; pulses = 0; b1 = 1'b0;
    @(posedge clk);
    do begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        base = ~b; expv = ~e; modv = m + 16'd3;
      end else start = 1'b0;
      if (red_ready) pulses++;
      if (cyc == 1) b1 = busy;
    end while (!valid && cyc < 2000);
    start = 1'b0;
    res = result; err = error; bend = busy;
  endtask

  task automatic full(input string tag, input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] m, input longint want);
    run(b, e, m, 1'b0);
    check({tag, "_res"}, longint'(res), want);
    check({tag, "_err"}, longint'(err), 0);
    check({tag, "_cyc"}, longint'(cyc), 628);
    check({tag, "_pulses"}, longint'(pulses), 33);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_result", longint'(result), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(valid), 0);
    check("rst_error", longint'(error), 0);
    check("rst_ready", longint'(red_ready), 0);
    check("rst_value", longint'(red_value), 0);
    check("rst_mod", longint'(red_mod), 0);
    rst_n = 1'b1;

    full("base", 16'd3, 16'd5, 16'd7, 5);
    check("base_busy1", longint'(b1), 1);
    check("base_busy_end", longint'(bend), 0);
    full("b4e13", 16'd4, 16'd13, 16'd497, 445);
    full("bigs", 16'hFFFF, 16'hFFFF, 16'hFFF1, sw_modexp(64'hFFFF, 64'hFFFF, 64'hFFF1));
    full("b_ge_m", 16'd10, 16'd3, 16'd7, 6);
    full("exp0", 16'd5, 16'd0, 16'd7, 1);
    full("mod1", 16'd5, 16'd9, 16'd1, 0);

    run(16'd5, 16'd9, 16'd0, 1'b0);
    check("zero_res", longint'(res), 0);
    check("zero_err", longint'(err), 1);
    check("zero_cyc", longint'(cyc), 1);
    check("zero_pulses", longint'(pulses), 0);
    check("zero_busy1", longint'(b1), 0);

    spur = 1'b1;
    run(16'd4, 16'd13, 16'd497, 1'b1);
    spur = 1'b0;
    check("hold_res", longint'(res), 445);
    check("hold_cyc", longint'(cyc), 628);
    check("hold_pulses", longint'(pulses), 33);
    check("hold_mod", longint'(red_mod), 497);

    @(negedge clk);
    base = 16'd3; expv = 16'd5; modv = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (198) @(negedge clk);
    check("pre_rst_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", longint'(result), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_valid", longint'(valid), 0);
    check("mid_rst_ready", longint'(red_ready), 0);
    check("mid_rst_value", longint'(red_value), 0);
    check("mid_rst_mod", longint'(red_mod), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    full("after_rst", 16'd10, 16'd3, 16'd7, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
